// File: rtl/window_read_arbiter.sv
// window_read_arbiter: shares the single read port of the window buffer among
// NUM_REQ requesters. Round-robin grant with burst lock (the owner keeps the
// port until its req_last beat is accepted), plus an owner-tag FIFO that routes
// each returned word back to the requester that issued its address.
//
// Handshake rule for every channel (req_*, buf_addr_*, buf_dout_*, rsp_*):
// a transfer happens on a rising clk edge where valid and ready are both 1.
// ready may depend combinationally on valid and on the other side's ready;
// the arbiter adds no pipeline stage in either direction.
module window_read_arbiter #(
  parameter int NUM_REQ      = 2,
  parameter int W_ADDR       = 10,
  parameter int W_DATA       = 18,
  parameter int MAX_INFLIGHT = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*W_ADDR-1:0] req_addr,
  input  logic [NUM_REQ-1:0]        req_last,
  output logic [NUM_REQ-1:0]        rsp_valid,
  input  logic [NUM_REQ-1:0]        rsp_ready,
  output logic [W_DATA-1:0]         rsp_data,
  output logic                      buf_addr_valid,
  input  logic                      buf_addr_ready,
  output logic [W_ADDR-1:0]         buf_addr_data,
  input  logic                      buf_dout_valid,
  output logic                      buf_dout_ready,
  input  logic [W_DATA-1:0]         buf_dout_data,
  output logic                      busy,
  output logic                      err,
  output logic                      dbg_state
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int PTR_W = (MAX_INFLIGHT > 1) ? $clog2(MAX_INFLIGHT) : 1;
  localparam int CNT_W = $clog2(MAX_INFLIGHT) + 1;

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } state_t;

  state_t           state_q;
  logic [IDX_W-1:0] rr_ptr_q;
  logic [IDX_W-1:0] rr_ptr_d;
  logic [IDX_W-1:0] owner_q;
  logic             err_q;

  logic [IDX_W-1:0] tag_mem_q [MAX_INFLIGHT];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W-1:0] rd_ptr_d;
  logic [CNT_W-1:0] count_q;

  logic [IDX_W-1:0] grant;
  logic             grant_valid;
  logic             tag_full;
  logic             tag_empty;
  logic [IDX_W-1:0] head;
  logic             issue_hs;
  logic             pop_hs;
  int               idx;

  assign tag_full  = (count_q == CNT_W'(MAX_INFLIGHT));
  assign tag_empty = (count_q == '0);
  assign head      = tag_mem_q[rd_ptr_q];

  // Grant selection: owner while locked, otherwise first valid requester
  // starting at rr_ptr and wrapping around.
  always_comb begin
    grant       = rr_ptr_q;
    grant_valid = 1'b0;
    idx         = 0;
    if (state_q == LOCK) begin
      grant       = owner_q;
      grant_valid = req_valid[owner_q];
    end else begin
      for (int k = 0; k < NUM_REQ; k++) begin
        idx = (int'(rr_ptr_q) + k) % NUM_REQ;
        if (!grant_valid && req_valid[idx]) begin
          grant_valid = 1'b1;
          grant       = IDX_W'(idx);
        end
      end
    end
  end

  // Issue and return paths are pure pass-through, gated off during reset.
  always_comb begin
    req_ready        = '0;
    rsp_valid        = '0;
    buf_addr_valid   = grant_valid & ~tag_full & ~rst;
    buf_addr_data    = req_addr[int'(grant)*W_ADDR +: W_ADDR];
    req_ready[grant] = buf_addr_ready & ~tag_full & ~rst;
    rsp_valid[head]  = buf_dout_valid & ~tag_empty & ~rst;
    buf_dout_ready   = rsp_ready[head] & ~tag_empty & ~rst;
  end

  assign rsp_data = buf_dout_data;
  assign issue_hs = buf_addr_valid & buf_addr_ready;
  assign pop_hs   = buf_dout_valid & buf_dout_ready;

  // Next round-robin start and FIFO pointer increments, wrapping explicitly.
  always_comb begin
    rr_ptr_d = (grant == IDX_W'(NUM_REQ - 1)) ? '0 : grant + 1'b1;
    wr_ptr_d = (wr_ptr_q == PTR_W'(MAX_INFLIGHT - 1)) ? '0 : wr_ptr_q + 1'b1;
    rd_ptr_d = (rd_ptr_q == PTR_W'(MAX_INFLIGHT - 1)) ? '0 : rd_ptr_q + 1'b1;
  end

  // Burst-lock FSM with round-robin pointer, owner and sticky error flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      owner_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      if (issue_hs) begin
        owner_q <= grant;
        if (req_last[grant]) begin
          state_q  <= IDLE;
          rr_ptr_q <= rr_ptr_d;
        end else begin
          state_q <= LOCK;
        end
      end
      if (buf_dout_valid && tag_empty) begin
        err_q <= 1'b1;
      end
    end
  end

  // Tag FIFO pointers and occupancy; reset drops any in-flight tags.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (issue_hs) begin
        wr_ptr_q <= wr_ptr_d;
      end
      if (pop_hs) begin
        rd_ptr_q <= rd_ptr_d;
      end
      case ({issue_hs, pop_hs})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Tag storage: the issuing requester index is written on each issue.
  always_ff @(posedge clk) begin
    if (issue_hs) begin
      tag_mem_q[wr_ptr_q] <= grant;
    end
  end

  assign busy      = (state_q == LOCK) | ~tag_empty;
  assign err       = err_q;
  assign dbg_state = (state_q == LOCK);

endmodule

// File: tb/tb_window_read_arbiter.sv
// Bench for window_read_arbiter: stimulus table from reset, hand-written
// multi-cycle sequences, then randomized traffic against a reference model
// and a window-buffer emulator with an in-order data scoreboard.
module tb_window_read_arbiter;

  localparam int NUM_REQ      = 2;
  localparam int W_ADDR       = 10;
  localparam int W_DATA       = 18;
  localparam int MAX_INFLIGHT = 4;
  localparam int SB_W         = W_DATA + 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [NUM_REQ-1:0]        req_valid, req_ready, req_last, rsp_valid, rsp_ready;
  logic [NUM_REQ*W_ADDR-1:0] req_addr;
  logic [W_DATA-1:0]         rsp_data, buf_dout_data;
  logic                      buf_addr_valid, buf_addr_ready, buf_dout_valid, buf_dout_ready;
  logic [W_ADDR-1:0]         buf_addr_data;
  logic                      busy, err, dbg_state;

  window_read_arbiter #(
    .NUM_REQ(NUM_REQ), .W_ADDR(W_ADDR), .W_DATA(W_DATA), .MAX_INFLIGHT(MAX_INFLIGHT)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_last(req_last),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .buf_addr_valid(buf_addr_valid), .buf_addr_ready(buf_addr_ready), .buf_addr_data(buf_addr_data),
    .buf_dout_valid(buf_dout_valid), .buf_dout_ready(buf_dout_ready), .buf_dout_data(buf_dout_data),
    .busy(busy), .err(err), .dbg_state(dbg_state)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  // reference model state
  bit  m_lock, m_err;
  int  m_owner, m_rr;
  int  tq[$];
  bit  x_issue, x_last, x_pop, x_errset;
  int  x_g;

  // sampled DUT outputs (negedge)
  logic [NUM_REQ-1:0] s_rr, s_rv;
  logic               s_bav, s_bdr, s_busy, s_err, s_state;
  logic [W_ADDR-1:0]  s_bad;
  logic [W_DATA-1:0]  s_rdata;

  // window buffer emulator and scoreboard
  bit                emu_on, sb_on;
  int                emu_rdy_mode, emu_dv_mode;
  logic [W_ADDR-1:0] emu_pend[$];
  logic [SB_W-1:0]   exp_q[$];

  int                acc;
  int                rem [NUM_REQ];
  logic [W_ADDR-1:0] cur [NUM_REQ];
  logic [W_ADDR-1:0] burst_addr [4];

  typedef struct {
    logic [1:0]  rv, rl;
    logic [9:0]  a0, a1;
    logic        bar, bdv;
    logic [17:0] bdd;
    logic [1:0]  rsr;
    logic [1:0]  e_rr;
    logic        e_bav;
    logic [9:0]  e_bad;
    logic [1:0]  e_rsv;
    logic        e_bdr, e_busy, e_err;
  } vec_t;
  vec_t vecs [12];

  function automatic logic [W_DATA-1:0] mem_f(input logic [W_ADDR-1:0] a);
    return {a[7:0], a} ^ 18'h15A5A;
  endfunction

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // expected outputs from the arbitration rules for the current inputs
  task automatic check_model();
    bit full, empty, gv;
    int g, h;
    logic [NUM_REQ-1:0] e_rr, e_rv;
    logic e_bav, e_bdr;
    if (rst) begin
      cmp("rst_req_ready", req_ready, 0);
      cmp("rst_addr_valid", buf_addr_valid, 0);
      cmp("rst_rsp_valid", rsp_valid, 0);
      cmp("rst_dout_ready", buf_dout_ready, 0);
      x_issue = 0; x_pop = 0; x_errset = 0; x_last = 0; x_g = 0;
      return;
    end
    empty = (tq.size() == 0);
    full  = (tq.size() == MAX_INFLIGHT);
    gv = 0;
    g  = m_rr;
    if (m_lock) begin
      g  = m_owner;
      gv = req_valid[g];
    end else begin
      for (int k = 0; k < NUM_REQ; k++) begin
        int i;
        i = (m_rr + k) % NUM_REQ;
        if (!gv && req_valid[i]) begin gv = 1; g = i; end
      end
    end
    e_bav = gv && !full;
    e_rr = '0;
    if (buf_addr_ready && !full) e_rr[g] = 1'b1;
    cmp("m_addr_valid", buf_addr_valid, e_bav);
    if (e_bav) cmp("m_addr_data", buf_addr_data, req_addr[g*W_ADDR +: W_ADDR]);
    cmp("m_req_ready", req_ready & req_valid, e_rr & req_valid);
    e_rv = '0;
    e_bdr = 1'b0;
    h = 0;
    if (!empty) begin
      h = tq[0];
      if (buf_dout_valid) e_rv[h] = 1'b1;
      e_bdr = rsp_ready[h];
    end
    cmp("m_rsp_valid", rsp_valid, e_rv);
    cmp("m_dout_ready", buf_dout_ready, e_bdr);
    if (buf_dout_valid) cmp("m_rsp_data", rsp_data, buf_dout_data);
    cmp("m_busy", busy, m_lock || !empty);
    cmp("m_err", err, m_err);
    cmp("m_state", dbg_state, m_lock);
    x_issue  = e_bav && buf_addr_ready;
    x_g      = g;
    x_last   = req_last[g];
    x_pop    = buf_dout_valid && e_bdr;
    x_errset = buf_dout_valid && empty;
  endtask

  task automatic model_update();
    if (rst) begin
      m_lock = 0; m_err = 0; m_owner = 0; m_rr = 0; tq.delete();
    end else begin
      if (x_errset) m_err = 1;
      if (x_pop) tq.delete(0);
      if (x_issue) begin
        tq.push_back(x_g);
        m_owner = x_g;
        if (x_last) begin m_lock = 0; m_rr = (x_g + 1) % NUM_REQ; end
        else m_lock = 1;
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic emu_drive();
    case (emu_rdy_mode)
      0:       buf_addr_ready = 1'b0;
      1:       buf_addr_ready = 1'b1;
      default: buf_addr_ready = ($urandom_range(0, 3) != 0);
    endcase
    if (emu_pend.size() > 0 && emu_dv_mode != 0 &&
        (emu_dv_mode == 1 || $urandom_range(0, 2) != 0)) begin
      buf_dout_valid = 1'b1;
      buf_dout_data  = mem_f(emu_pend[0]);
    end else begin
      buf_dout_valid = 1'b0;
      buf_dout_data  = W_DATA'($urandom);
    end
  endtask

  task automatic emu_update();
    if (rst) begin
      emu_pend.delete();
    end else begin
      if (buf_dout_valid && s_bdr && emu_pend.size() > 0) emu_pend.delete(0);
      if (s_bav && buf_addr_ready) emu_pend.push_back(s_bad);
    end
  endtask

  // ---------------- scoreboard ----------------
  task automatic sb_update();
    if (rst) begin
      exp_q.delete();
      return;
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (s_rv[i] && rsp_ready[i]) begin
        if (exp_q.size() == 0) begin
          cmp("sb_unexpected_rsp", 1, 0);
        end else begin
          logic [SB_W-1:0] got;
          got = {1'(i), s_rdata};
          cmp("sb_rsp", got, exp_q.pop_front());
        end
      end
    end
    if (x_issue) exp_q.push_back({1'(x_g), mem_f(req_addr[x_g*W_ADDR +: W_ADDR])});
  endtask

  task automatic step();
    if (emu_on) emu_drive();
    @(negedge clk);
    check_model();
    s_rr = req_ready; s_rv = rsp_valid; s_bav = buf_addr_valid; s_bad = buf_addr_data;
    s_bdr = buf_dout_ready; s_rdata = rsp_data; s_busy = busy; s_err = err; s_state = dbg_state;
    @(posedge clk);
    if (sb_on) sb_update();
    model_update();
    if (emu_on) emu_update();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = '0;
    step();
    rst = 1'b0;
  endtask

  task automatic drain();
    req_valid = '0;
    rsp_ready = '1;
    emu_dv_mode = 1;
    for (int t = 0; t < 100 && (exp_q.size() > 0 || emu_pend.size() > 0); t++) step();
    cmp("drain_empty", exp_q.size(), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; req_valid = '0; req_last = '0; req_addr = '0; rsp_ready = '0;
    buf_addr_ready = 1'b0; buf_dout_valid = 1'b0; buf_dout_data = '0;
    emu_on = 0; sb_on = 0; emu_rdy_mode = 1; emu_dv_mode = 1;
    burst_addr[0] = 10'd0; burst_addr[1] = 10'd23; burst_addr[2] = 10'd552; burst_addr[3] = 10'd575;

    //          rv     rl     a0     a1     bar   bdv   bdd        rsr     e_rr   bav   bad    rsv    bdr   busy  err
    vecs[0]  = '{2'b11, 2'b11, 10'd5, 10'd9, 1'b1, 1'b0, 18'h0,     2'b11,  2'b01, 1'b1, 10'd5, 2'b00, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{2'b11, 2'b11, 10'd5, 10'd9, 1'b1, 1'b0, 18'h0,     2'b11,  2'b10, 1'b1, 10'd9, 2'b00, 1'b1, 1'b1, 1'b0};
    vecs[2]  = '{2'b11, 2'b11, 10'd5, 10'd9, 1'b1, 1'b0, 18'h0,     2'b11,  2'b01, 1'b1, 10'd5, 2'b00, 1'b1, 1'b1, 1'b0};
    vecs[3]  = '{2'b11, 2'b11, 10'd5, 10'd9, 1'b1, 1'b0, 18'h0,     2'b11,  2'b10, 1'b1, 10'd9, 2'b00, 1'b1, 1'b1, 1'b0};
    vecs[4]  = '{2'b11, 2'b11, 10'd5, 10'd9, 1'b1, 1'b1, 18'h111,   2'b11,  2'b00, 1'b0, 10'd0, 2'b01, 1'b1, 1'b1, 1'b0};
    vecs[5]  = '{2'b00, 2'b11, 10'd5, 10'd9, 1'b0, 1'b1, 18'h222,   2'b11,  2'b00, 1'b0, 10'd0, 2'b10, 1'b1, 1'b1, 1'b0};
    vecs[6]  = '{2'b00, 2'b11, 10'd5, 10'd9, 1'b0, 1'b1, 18'h333,   2'b10,  2'b00, 1'b0, 10'd0, 2'b01, 1'b0, 1'b1, 1'b0};
    vecs[7]  = '{2'b00, 2'b11, 10'd5, 10'd9, 1'b0, 1'b1, 18'h333,   2'b01,  2'b00, 1'b0, 10'd0, 2'b01, 1'b1, 1'b1, 1'b0};
    vecs[8]  = '{2'b00, 2'b11, 10'd5, 10'd9, 1'b0, 1'b1, 18'h444,   2'b11,  2'b00, 1'b0, 10'd0, 2'b10, 1'b1, 1'b1, 1'b0};
    vecs[9]  = '{2'b00, 2'b11, 10'd5, 10'd9, 1'b0, 1'b0, 18'h0,     2'b11,  2'b00, 1'b0, 10'd0, 2'b00, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{2'b00, 2'b11, 10'd5, 10'd9, 1'b0, 1'b1, 18'h555,   2'b11,  2'b00, 1'b0, 10'd0, 2'b00, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{2'b00, 2'b11, 10'd5, 10'd9, 1'b0, 1'b0, 18'h0,     2'b11,  2'b00, 1'b0, 10'd0, 2'b00, 1'b0, 1'b0, 1'b1};

    step();
    step();
    rst = 1'b0;
    step();
    cmp("reset_busy", s_busy, 0);
    cmp("reset_err", s_err, 0);
    cmp("reset_state", s_state, 0);

    // table: alternating grants, FIFO full, routed returns, error injection
    for (int v = 0; v < 12; v++) begin
      req_valid = vecs[v].rv; req_last = vecs[v].rl; req_addr = {vecs[v].a1, vecs[v].a0};
      buf_addr_ready = vecs[v].bar; buf_dout_valid = vecs[v].bdv; buf_dout_data = vecs[v].bdd;
      rsp_ready = vecs[v].rsr;
      step();
      cmp($sformatf("vec%0d_req_ready", v), s_rr & vecs[v].rv, vecs[v].e_rr);
      cmp($sformatf("vec%0d_addr_valid", v), s_bav, vecs[v].e_bav);
      if (vecs[v].e_bav) cmp($sformatf("vec%0d_addr_data", v), s_bad, vecs[v].e_bad);
      cmp($sformatf("vec%0d_rsp_valid", v), s_rv, vecs[v].e_rsv);
      if (vecs[v].e_rsv != 0) cmp($sformatf("vec%0d_rsp_data", v), s_rdata, vecs[v].bdd);
      cmp($sformatf("vec%0d_dout_ready", v), s_bdr, vecs[v].e_bdr);
      cmp($sformatf("vec%0d_busy", v), s_busy, vecs[v].e_busy);
      cmp($sformatf("vec%0d_err", v), s_err, vecs[v].e_err);
    end
    buf_dout_valid = 1'b0;
    do_reset();
    step();
    cmp("err_cleared", s_err, 0);

    emu_on = 1;
    sb_on  = 1;

    // burst lock: req0 4-beat burst while req1 waits
    do_reset();
    emu_rdy_mode = 1; emu_dv_mode = 1; rsp_ready = '1;
    for (int k = 0; k < 4; k++) begin
      req_valid = 2'b11; req_last = {1'b1, (k == 3)}; req_addr = {10'd100, burst_addr[k]};
      step();
      cmp($sformatf("burst_beat%0d_ready", k), s_rr, 2'b01);
    end
    req_addr = {10'd100, 10'd7}; req_last = 2'b11;
    step();
    cmp("burst_handover", s_rr, 2'b10);
    drain();

    // tag FIFO full blocks issue, one pop resumes it
    do_reset();
    emu_rdy_mode = 1; emu_dv_mode = 1; rsp_ready = '0; req_valid = 2'b01; req_last = 2'b11;
    acc = 0;
    for (int k = 0; k < 4; k++) begin
      req_addr = {10'd0, 10'(k + 40)};
      step();
      if (s_rr[0]) acc++;
    end
    cmp("full_accepted", acc, 4);
    step();
    cmp("full_addr_valid", s_bav, 0);
    cmp("full_req_ready", s_rr, 0);
    cmp("full_busy", s_busy, 1);
    rsp_ready = 2'b01;
    step();
    cmp("full_pop_ready", s_bdr, 1);
    rsp_ready = '0;
    step();
    cmp("full_resume", s_bav, 1);
    drain();

    // buffer address stall
    do_reset();
    emu_rdy_mode = 0; emu_dv_mode = 1; rsp_ready = '1;
    req_valid = 2'b10; req_last = 2'b11; req_addr = {10'd77, 10'd0};
    for (int k = 0; k < 5; k++) begin
      step();
      cmp("stall_req_ready", s_rr, 0);
      cmp("stall_addr_data", s_bad, 77);
      cmp("stall_addr_valid", s_bav, 1);
    end
    cmp("stall_no_push", s_busy, 0);
    emu_rdy_mode = 1;
    step();
    cmp("stall_release", s_rr, 2'b10);
    req_valid = '0;
    step();
    cmp("stall_busy_after", s_busy, 1);
    drain();

    // reset in the middle of a locked burst with two reads in flight
    do_reset();
    emu_rdy_mode = 1; emu_dv_mode = 0; rsp_ready = '1; req_valid = 2'b01; req_last = 2'b00;
    for (int k = 0; k < 2; k++) begin
      req_addr = {10'd0, 10'(200 + k)};
      step();
    end
    req_valid = '0;
    step();
    cmp("mid_lock_state", s_state, 1);
    cmp("mid_lock_busy", s_busy, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    emu_dv_mode = 1; req_valid = 2'b11; req_last = 2'b11; req_addr = {10'd301, 10'd300};
    step();
    cmp("post_rst_state", s_state, 0);
    cmp("post_rst_busy", s_busy, 0);
    cmp("post_rst_grant", s_rr, 2'b01);
    drain();

    // randomized traffic
    do_reset();
    emu_rdy_mode = 2; emu_dv_mode = 2;
    for (int i = 0; i < NUM_REQ; i++) begin rem[i] = 0; cur[i] = '0; end
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (rem[i] == 0 && $urandom_range(0, 3) == 0) begin
          rem[i] = $urandom_range(1, 4);
          cur[i] = W_ADDR'($urandom);
        end
        req_valid[i] = (rem[i] > 0) && ($urandom_range(0, 4) != 0);
        req_last[i]  = (rem[i] == 1);
        req_addr[i*W_ADDR +: W_ADDR] = cur[i];
      end
      rsp_ready = NUM_REQ'($urandom);
      step();
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req_valid[i] && s_rr[i]) begin
          rem[i]--;
          cur[i] = W_ADDR'($urandom);
        end
      end
    end
    // finish any open burst so the lock releases, then drain
    for (int t = 0; t < 200 && (rem[0] > 0 || rem[1] > 0); t++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        req_valid[i] = (rem[i] > 0);
        req_last[i]  = (rem[i] == 1);
        req_addr[i*W_ADDR +: W_ADDR] = cur[i];
      end
      rsp_ready = '1;
      step();
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req_valid[i] && s_rr[i]) rem[i]--;
      end
    end
    drain();
    step();
    cmp("final_busy", s_busy, 0);
    cmp("final_err", s_err, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
